// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM stage: loads/stores over a single-outstanding req/ready bus, MEM/WB register
//   ex_*   : EX/MEM operands (valid, alu result/address, store data, rd, funct3, control bits)
//   dmem_* : data-memory bus (req/we/addr/wdata/be out, ready/rdata in)
//   mem_stall : freezes the upstream pipeline while a transaction is outstanding
//   wb_*   : registered MEM/WB slot; wb_data doubles as the mem_wb forwarding source
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_misaligned,
    output logic        wb_bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           wb_valid_q, wb_valid_d;
    logic           wb_reg_write_q, wb_reg_write_d;
    logic [4:0]     wb_rd_q, wb_rd_d;
    logic [31:0]    wb_data_q, wb_data_d;
    logic           wb_misaligned_q, wb_misaligned_d;
    logic           wb_bus_err_q, wb_bus_err_d;

    logic           mem_op, is_store, is_load, misaligned, access, timeout;
    logic [1:0]     a_lo;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    load_data;

    // Access decode, bus lanes and load extraction
    always_comb begin
        a_lo       = ex_alu_result[1:0];
        mem_op     = ex_valid & (ex_mem_read | ex_mem_write);
        is_store   = mem_op & ex_mem_write;   // read+write together counts as a store
        is_load    = mem_op & ~ex_mem_write;
        misaligned = ((ex_funct3[1:0] == 2'b01) & a_lo[0]) |
                     ((ex_funct3[1:0] == 2'b10) & (a_lo != 2'b00));
        access     = mem_op & ~misaligned;

        dmem_we    = is_store;
        dmem_addr  = {ex_alu_result[31:2], 2'b00};
        case (ex_funct3[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << a_lo;
                dmem_wdata = {4{ex_rs2_data[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << a_lo;
                dmem_wdata = {2{ex_rs2_data[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = ex_rs2_data;
            end
        endcase

        case (a_lo)
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = a_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ex_funct3)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // Transaction FSM: stall is dropped in the cycle that completes or times out
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    dmem_req = 1'b1;
                    if (!dmem_ready) begin
                        mem_stall = 1'b1;
                        state_d   = S_WAIT;
                        cnt_d     = CW'(1);
                    end
                end
            end
            default: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
        endcase
        // Reset takes effect on the bus in the very cycle it is sampled
        if (!reset) begin
            dmem_req  = 1'b0;
            mem_stall = 1'b0;
            timeout   = 1'b0;
            state_d   = S_IDLE;
            cnt_d     = '0;
        end
    end

    // MEM/WB next value: bubble while stalled, rd/data held
    always_comb begin
        wb_valid_d      = 1'b0;
        wb_reg_write_d  = 1'b0;
        wb_misaligned_d = 1'b0;
        wb_bus_err_d    = 1'b0;
        wb_rd_d         = wb_rd_q;
        wb_data_d       = wb_data_q;
        if (!mem_stall) begin
            wb_valid_d      = ex_valid;
            wb_rd_d         = ex_rd;
            wb_data_d       = (is_load & ~misaligned & ~timeout) ? load_data : ex_alu_result;
            wb_misaligned_d = mem_op & misaligned;
            wb_bus_err_d    = timeout;
            wb_reg_write_d  = ex_valid & ex_reg_write & ~is_store &
                              ~(mem_op & misaligned) & ~timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            wb_misaligned_q <= 1'b0;
            wb_bus_err_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            wb_misaligned_q <= wb_misaligned_d;
            wb_bus_err_q    <= wb_bus_err_d;
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign wb_misaligned = wb_misaligned_q;
    assign wb_bus_err    = wb_bus_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_misaligned;
    logic        wb_bus_err;

    int n_cmp = 0;
    int n_bad = 0;
    int stalls;

    memory_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_misaligned(wb_misaligned), .wb_bus_err(wb_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                      input logic [4:0] rd, input logic [2:0] f3,
                      input logic rd_en, input logic wr_en, input logic rw);
        ex_valid      = v;
        ex_alu_result = alu;
        ex_rs2_data   = rs2;
        ex_rd         = rd;
        ex_funct3     = f3;
        ex_mem_read   = rd_en;
        ex_mem_write  = wr_en;
        ex_reg_write  = rw;
    endtask

    initial begin
        reset      = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        op(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_dmem_req", 32'(dmem_req), 0);
        chk("rst_mem_stall", 32'(mem_stall), 0);

        // ALU pass-through
        tick();
        reset = 1'b1;
        op(1, 32'h1234, 0, 5, 3'b000, 0, 0, 1);
        #1;
        chk("pt_req", 32'(dmem_req), 0);
        tick();
        chk("pt_wb_data", wb_data, 32'h1234);
        chk("pt_wb_rd", 32'(wb_rd), 5);
        chk("pt_wb_rw", 32'(wb_reg_write), 1);
        chk("pt_wb_valid", 32'(wb_valid), 1);

        // zero-wait loads from the same word
        dmem_ready = 1'b1;
        dmem_rdata = 32'h80FF_0011;
        op(1, 32'h103, 0, 6, 3'b000, 1, 0, 1);
        #1;
        chk("lb_req", 32'(dmem_req), 1);
        chk("lb_stall", 32'(mem_stall), 0);
        chk("lb_addr", dmem_addr, 32'h100);
        tick();
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_rw", 32'(wb_reg_write), 1);
        op(1, 32'h103, 0, 6, 3'b100, 1, 0, 1);
        tick();
        chk("lbu_data", wb_data, 32'h0000_0080);
        op(1, 32'h102, 0, 6, 3'b001, 1, 0, 1);
        tick();
        chk("lh_data", wb_data, 32'hFFFF_80FF);
        op(1, 32'h100, 0, 6, 3'b101, 1, 0, 1);
        tick();
        chk("lhu_data", wb_data, 32'h0000_0011);

        // stores
        op(1, 32'h101, 32'hAABB_CCDD, 8, 3'b000, 0, 1, 1);
        #1;
        chk("sb_be", 32'(dmem_be), 32'b0010);
        chk("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
        chk("sb_addr", dmem_addr, 32'h100);
        chk("sb_we", 32'(dmem_we), 1);
        tick();
        chk("sb_wb_rw", 32'(wb_reg_write), 0);
        chk("sb_wb_valid", 32'(wb_valid), 1);
        op(1, 32'h102, 32'hAABB_CCDD, 8, 3'b001, 0, 1, 0);
        #1;
        chk("sh_be", 32'(dmem_be), 32'b1100);
        chk("sh_wdata", dmem_wdata, 32'hCCDD_CCDD);
        tick();
        op(1, 32'h104, 32'hAABB_CCDD, 8, 3'b010, 1, 1, 0);
        #1;
        chk("sw_be", 32'(dmem_be), 32'b1111);
        chk("sw_wdata", dmem_wdata, 32'hAABB_CCDD);
        chk("rw_both_we", 32'(dmem_we), 1);
        tick();

        // LW with three wait cycles
        dmem_ready = 1'b0;
        dmem_rdata = 32'h1234_5678;
        op(1, 32'h200, 0, 7, 3'b010, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("lw_wait_stall%0d", i), 32'(mem_stall), 1);
            chk($sformatf("lw_wait_req%0d", i), 32'(dmem_req), 1);
            tick();
            chk($sformatf("lw_wait_bubble%0d", i), 32'(wb_valid), 0);
        end
        dmem_ready = 1'b1;
        #1;
        chk("lw_ready_stall", 32'(mem_stall), 0);
        tick();
        chk("lw_data", wb_data, 32'h1234_5678);
        chk("lw_rd", 32'(wb_rd), 7);
        chk("lw_valid", 32'(wb_valid), 1);
        chk("lw_rw", 32'(wb_reg_write), 1);

        // timeout with ready never asserted
        dmem_ready = 1'b0;
        op(1, 32'h300, 0, 9, 3'b010, 1, 0, 1);
        stalls = 0;
        #1;
        while (mem_stall && stalls < 20) begin
            stalls++;
            tick();
            #1;
        end
        chk("to_stall_cycles", 32'(stalls), 4);
        chk("to_last_req", 32'(dmem_req), 1);
        tick();
        chk("to_bus_err", 32'(wb_bus_err), 1);
        chk("to_rw", 32'(wb_reg_write), 0);
        chk("to_valid", 32'(wb_valid), 1);
        op(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("to_req_drop", 32'(dmem_req), 0);

        // misaligned LW
        tick();
        op(1, 32'h102, 0, 10, 3'b010, 1, 0, 1);
        #1;
        chk("mis_req", 32'(dmem_req), 0);
        chk("mis_stall", 32'(mem_stall), 0);
        tick();
        chk("mis_flag", 32'(wb_misaligned), 1);
        chk("mis_rw", 32'(wb_reg_write), 0);
        chk("mis_bus_err", 32'(wb_bus_err), 0);

        // reset in the middle of WAIT, then a late ready
        op(1, 32'h400, 0, 11, 3'b010, 1, 0, 1);
        #1;
        chk("rw_stall_pre", 32'(mem_stall), 1);
        tick();
        reset = 1'b0;
        #1;
        chk("rw_req_in_rst", 32'(dmem_req), 0);
        chk("rw_stall_in_rst", 32'(mem_stall), 0);
        tick();
        reset      = 1'b1;
        dmem_ready = 1'b1;
        op(0, 32'h400, 0, 11, 3'b010, 1, 0, 1);
        #1;
        chk("rw_req_after", 32'(dmem_req), 0);
        chk("rw_stall_after", 32'(mem_stall), 0);
        chk("rw_wb_valid", 32'(wb_valid), 0);
        chk("rw_wb_data", wb_data, 0);
        chk("rw_wb_rd", 32'(wb_rd), 0);
        chk("rw_wb_flags", {28'd0, wb_reg_write, wb_misaligned, wb_bus_err, 1'b0}, 0);
        tick();
        chk("rw_late_ready_ignored", 32'(wb_valid), 0);
        chk("rw_late_rw", 32'(wb_reg_write), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the five-stage RISC-V pipeline. It consumes the EX/MEM operands produced by the execute stage: ALU result (address or value), forwarded rs2 store data, destination register, funct3 and control bits. It performs loads and stores over a single-outstanding req/ready data-memory bus, and registers the MEM/WB result. The registered `wb_data` is the `mem_wb_write_data` forwarding source used by the execute stage.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before a bus error is declared (≥2)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-low reset
- ex_valid  input  1  EX/MEM slot holds a valid instruction
- ex_alu_result  input  32  ALU result; effective address for loads/stores
- ex_rs2_data  input  32  forwarded store data
- ex_rd  input  5  destination register
- ex_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_mem_read  input  1  load
- ex_mem_write  input  1  store
- ex_reg_write  input  1  instruction writes rd
- dmem_req  output  1  bus request
- dmem_we  output  1  1 = store
- dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  output  32  lane-replicated store data
- dmem_be  output  4  byte enables
- dmem_ready  input  1  transaction completes this cycle
- dmem_rdata  input  32  read word, valid when dmem_ready
- mem_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- wb_valid  output  1  registered: MEM/WB slot valid
- wb_reg_write  output  1  registered: write rd
- wb_rd  output  5  registered destination
- wb_data  output  32  registered write-back value
- wb_misaligned  output  1  registered: misaligned access flagged
- wb_bus_err  output  1  registered: bus timeout flagged

## Operation
- mem_op = ex_valid & (ex_mem_read | ex_mem_write). If both read and write are set, treat the op as a store.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0. A misaligned op issues no request, does not stall, and retires with wb_misaligned=1, wb_reg_write=0.
- Non-memory ops pass through: wb_data=ex_alu_result and wb_reg_write=ex_reg_write, registered in one cycle.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{rs2[7:0]}}
  - SH: be=0011<<addr[1:0], wdata={2{rs2[15:0]}}
  - SW: be=1111, wdata=rs2
  - A store sets wb_reg_write=0.
- Load extraction: select the byte or halfword of dmem_rdata indexed by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W takes the word unchanged. dmem_be is computed as for stores; the bus ignores it on reads.
- FSM states IDLE and WAIT, with counter cnt (width $clog2(TIMEOUT_CYCLES)+1).
  - IDLE: an aligned mem_op drives dmem_req=1 combinationally.
    - dmem_ready=1 → complete this cycle and stay in IDLE.
    - dmem_ready=0 → mem_stall=1, go to WAIT, cnt←1.
  - WAIT: dmem_req=1 and mem_stall=1 (stall deasserts in the completing cycle).
    - dmem_ready=1 → complete, go to IDLE, mem_stall=0.
    - Otherwise, when cnt==TIMEOUT_CYCLES: retire with wb_bus_err=1, wb_reg_write=0, return to IDLE, and drop dmem_req from the next cycle.
    - Otherwise cnt increments.
- Bus addr/we/wdata/be are combinational from the ex_* inputs. They stay stable during a stall because EX/MEM is frozen.
- While mem_stall=1 the MEM/WB register loads a bubble (wb_valid=0, wb_reg_write=0); wb_rd and wb_data hold their previous values.
- Reset (reset=0 at an edge) applies at any time, including in WAIT:
  - state returns to IDLE, cnt=0;
  - all wb_* outputs become 0;
  - dmem_req=0 and mem_stall=0 in the cycle that reset is sampled low.
  - A dmem_ready arriving after reset is ignored.

## Timing
- Zero-wait access (ready in the request cycle): wb_* valid one edge later, no stall.
- Ready after N wait cycles: mem_stall is high for N cycles; wb_* is updated at the edge of the ready cycle.
- Timeout: mem_stall is high for TIMEOUT_CYCLES cycles; wb_bus_err is visible the cycle after the last stall cycle.
- The bus has one outstanding transaction and is never re-requested back-to-back within a transaction.
- Consecutive memory ops: the next request may be issued in the cycle after completion.

## Test plan
- ALU pass-through: ex_alu_result=0x1234, rd=5, reg_write=1 → next cycle wb_data=0x1234, wb_rd=5, wb_reg_write=1, no dmem_req.
- LB at addr 0x103 with rdata=0x80FF_0011 and ready in the same cycle → wb_data=0xFFFF_FF80; LBU at the same address → 0x0000_0080; LH at 0x102 → 0xFFFF_80FF.
- SB at 0x101 with rs2=0xAABBCCDD → dmem_be=0010, wdata=0xDDDDDDDD, dmem_addr=0x100, dmem_we=1, wb_reg_write=0.
- LW with ready after 3 wait cycles → mem_stall high exactly 3 cycles, wb_valid=0 during the stall, wb_data=rdata on the edge of the ready cycle.
- TIMEOUT_CYCLES=4, ready never asserted → 4 stall cycles, then wb_bus_err=1, wb_reg_write=0, dmem_req=0.
- LW at 0x102 → no request, no stall, wb_misaligned=1. Separately, reset=0 asserted mid-WAIT → next cycle dmem_req=0, mem_stall=0, all wb_* outputs 0.
